// File: rtl/fir_coef_loader.sv
// Streams NUM_TAPS coefficients into a FIR coefficient port, then waits out the
// filter's pipeline latency before flagging the new coefficient set as live.
module fir_coef_loader #(
  parameter int NUM_TAPS = 10,
  parameter int COEF_W   = 8,
  parameter int IDX_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [COEF_W-1:0] s_data,
  output logic              s_ready,
  output logic              coef_write_enable,
  output logic [IDX_W-1:0]  coef_number,
  output logic [COEF_W-1:0] coef_value,
  output logic              busy,
  output logic              done,
  output logic              filter_ready
);

  localparam int SET_W = $clog2(NUM_TAPS + 1);
  localparam logic [IDX_W-1:0] LAST_TAP   = IDX_W'(NUM_TAPS - 1);
  localparam logic [SET_W-1:0] SETTLE_LEN = SET_W'(NUM_TAPS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [IDX_W-1:0]    tap_r, tap_s;
  logic [SET_W-1:0]    settle_r, settle_s;
  logic                cwe_r, cwe_s;
  logic [IDX_W-1:0]    num_r, num_s;
  logic [COEF_W-1:0]   val_r, val_s;
  logic                done_r, done_s;
  logic                fready_r, fready_s;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      tap_r    <= '0;
      settle_r <= '0;
      cwe_r    <= 1'b0;
      num_r    <= '0;
      val_r    <= '0;
      done_r   <= 1'b0;
      fready_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      tap_r    <= tap_s;
      settle_r <= settle_s;
      cwe_r    <= cwe_s;
      num_r    <= num_s;
      val_r    <= val_s;
      done_r   <= done_s;
      fready_r <= fready_s;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s  = state_r;
    tap_s    = tap_r;
    settle_s = settle_r;
    cwe_s    = 1'b0;
    num_s    = num_r;
    val_s    = val_r;
    done_s   = 1'b0;
    fready_s = fready_r;
    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          state_s  = LOAD;
          tap_s    = '0;
          fready_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        // A beat accepted together with abort is still written out.
        if (s_valid) begin
          cwe_s = 1'b1;
          num_s = tap_r;
          val_s = s_data;
          if (tap_r == LAST_TAP) begin
            state_s  = SETTLE;
            settle_s = SETTLE_LEN;
          end else begin
            tap_s = tap_r + IDX_W'(1);
          end
        end else begin
          cwe_s = 1'b0;
        end
        if (abort) begin
          state_s  = IDLE;
          fready_s = 1'b0;
        end else begin
          fready_s = fready_r;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_s  = IDLE;
          fready_s = 1'b0;
        end else if (settle_r == '0) begin
          state_s  = IDLE;
          done_s   = 1'b1;
          fready_s = 1'b1;
        end else begin
          settle_s = settle_r - SET_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign s_ready           = (state_r == LOAD);
  assign busy              = (state_r != IDLE);
  assign coef_write_enable = cwe_r;
  assign coef_number       = num_r;
  assign coef_value        = val_r;
  assign done              = done_r;
  assign filter_ready      = fready_r;

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed + randomized bench for fir_coef_loader: a monitor records strobes and
// done pulses; each load is compared against the expected tap sequence and timing.
module tb_fir_coef_loader;

  localparam int NT = 10;
  localparam int CW = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst, start, abort, s_valid;
  logic [CW-1:0] s_data;
  logic          s_ready, coef_write_enable, busy, done, filter_ready;
  logic [IW-1:0] coef_number;
  logic [CW-1:0] coef_value;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int wr_cyc[$];
  int wr_num[$];
  int wr_val[$];
  int done_cyc[$];
  logic [CW-1:0] tx [NT];

  // Reference filter fed from the loader's coefficient port
  logic [CW-1:0] fc [NT];
  int            fx [NT] = '{default: 0};
  int            fy = 0;
  int            x_in = 0;

  fir_coef_loader #(.NUM_TAPS(NT), .COEF_W(CW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .coef_write_enable(coef_write_enable), .coef_number(coef_number),
    .coef_value(coef_value), .busy(busy), .done(done), .filter_ready(filter_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (coef_write_enable && coef_number < NT) fc[coef_number] <= coef_value;

  always @(posedge clk) begin
    int acc;
    acc = int'(fc[0]) * x_in;
    for (int k = 1; k < NT; k++) acc += int'(fc[k]) * fx[k-1];
    for (int k = NT - 1; k > 0; k--) fx[k] <= fx[k-1];
    fx[0] <= x_in;
    fy    <= acc;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (coef_write_enable) begin
        wr_cyc.push_back(cyc);
        wr_num.push_back(int'(coef_number));
        wr_val.push_back(int'(coef_value));
      end
      if (done) done_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_cwe"}, 32'(coef_write_enable), 32'd0);
    chk({tag, "_num"}, 32'(coef_number), 32'd0);
    chk({tag, "_val"}, 32'(coef_value), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_fready"}, 32'(filter_ready), 32'd0);
  endtask

  // mode: 0 continuous, 1 alternating, 2 random valid; abort_beat>0 aborts on that beat;
  // post: 0 run to done, 1 async reset during settle
  task automatic run_load(input int mode, input int abort_beat, input bit poke, input int post);
    int  idx = 0;
    int  t   = 0;
    int  n_exp;
    bit  v;
    n_exp = (abort_beat > 0) ? abort_beat : NT;
    wr_cyc.delete(); wr_num.delete(); wr_val.delete(); done_cyc.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("fready_cleared", 32'(filter_ready), 32'd0);
    while (idx < n_exp && t < 300) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (t % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      chk("s_ready_load", 32'(s_ready), 32'd1);
      s_valid = v;
      s_data  = tx[idx];
      start   = (poke && t == 2);
      if (v) begin
        idx++;
        if (idx == abort_beat) abort = 1'b1;
      end
      @(negedge clk);
      abort = 1'b0;
      start = 1'b0;
      t++;
    end
    s_valid = 1'b0;
    s_data  = CW'($urandom);
    if (abort_beat > 0) begin
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_s_ready", 32'(s_ready), 32'd0);
      s_valid = 1'b1;
      repeat (3) @(negedge clk);
      s_valid = 1'b0;
      repeat (15) @(negedge clk);
      chk("abort_no_done", 32'(done_cyc.size()), 32'd0);
      chk("abort_fready", 32'(filter_ready), 32'd0);
    end else begin
      chk("settle_s_ready", 32'(s_ready), 32'd0);
      chk("settle_busy", 32'(busy), 32'd1);
      if (post == 1) begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_settle");
        @(negedge clk); rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("rst_no_done", 32'(done_cyc.size()), 32'd0);
        chk("rst_fready", 32'(filter_ready), 32'd0);
      end else begin
        if (poke) begin
          start = 1'b1; @(negedge clk); start = 1'b0;
        end
        for (int k = 0; k < 40 && done_cyc.size() == 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("done_count", 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() > 0 && wr_cyc.size() > 0)
          chk("done_latency", 32'(done_cyc[0] - wr_cyc[wr_cyc.size()-1]), 32'(NT + 1));
        chk("fready_set", 32'(filter_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
      end
    end
    chk("write_count", 32'(wr_num.size()), 32'(n_exp));
    for (int i = 0; i < n_exp && i < wr_num.size(); i++) begin
      chk("write_num", 32'(wr_num[i]), 32'(i));
      chk("write_val", 32'(wr_val[i]), 32'(tx[i]));
      if (mode == 0 && i > 0) chk("write_b2b", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_wait_busy", 32'(busy), 32'd0);

    // abort has priority over start in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_prio", 32'(busy), 32'd0);

    for (int i = 0; i < NT; i++) tx[i] = CW'(i + 1);
    run_load(0, 0, 1'b0, 0);

    for (int i = 0; i < NT; i++) tx[i] = CW'(8'hA0 + i);
    run_load(1, 0, 1'b0, 0);

    for (int i = 0; i < NT; i++) tx[i] = CW'($urandom);
    run_load(0, 4, 1'b0, 0);

    for (int i = 0; i < NT; i++) tx[i] = CW'($urandom);
    run_load(2, 0, 1'b1, 0);

    for (int i = 0; i < NT; i++) tx[i] = CW'($urandom);
    run_load(0, 0, 1'b0, 1);

    for (int i = 0; i < NT; i++) tx[i] = CW'($urandom);
    run_load(2, 0, 1'b0, 0);

    // impulse response through the freshly loaded filter
    for (int i = 0; i < NT; i++) tx[i] = (i == 0) ? CW'(1) : CW'(0);
    run_load(2, 0, 1'b0, 0);
    repeat (NT + 2) @(negedge clk);
    chk("fir_quiet", 32'(fy), 32'd0);
    x_in = 5;
    @(negedge clk); x_in = 0;
    chk("fir_impulse", 32'(fy), 32'd5);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fir_tail", 32'(fy), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_coef_loader.md
FIR_COEF_LOADER -- requirements
Module: fir_coef_loader

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 10: number of filter coefficients written per load.
REQ-002 SHALL have parameter COEF_W, default 8: width of one coefficient.
REQ-003 SHALL have parameter IDX_W, default 4: width of coef_number; 2^IDX_W >= NUM_TAPS.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 SHALL have ports, one per line:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request a full coefficient load.
- abort  input  1  cancel a load in progress.
- s_valid  input  1  coefficient stream valid.
- s_data  input  COEF_W  coefficient stream data, tap 0 first.
- s_ready  output  1  loader accepts s_data.
- coef_write_enable  output  1  write strobe to the filter coefficient port.
- coef_number  output  IDX_W  tap index being written.
- coef_value  output  COEF_W  coefficient being written.
- busy  output  1  high in LOAD or SETTLE.
- done  output  1  one-cycle pulse when the load and settle have completed.
- filter_ready  output  1  filter output reflects only the new coefficient set.

Function
REQ-006 SHALL implement the states IDLE, LOAD and SETTLE.
REQ-007 IDLE: start=1 SHALL move to LOAD, clear the tap counter to 0 and clear filter_ready.
REQ-008 LOAD: s_ready SHALL equal 1 combinationally from state; the handshake is s_valid && s_ready on a rising edge.
REQ-009 Each handshake SHALL register coef_write_enable=1, coef_number=tap counter and coef_value=s_data, all visible in the next cycle, and SHALL increment the tap counter.
REQ-010 coef_write_enable SHALL be high exactly one cycle per handshake; the beat gap equals the producer's s_valid gap.
REQ-011 coef_number and coef_value SHALL hold their last written values when coef_write_enable=0.
REQ-012 The handshake with the counter at NUM_TAPS-1 SHALL move to SETTLE and load the settle counter with NUM_TAPS; s_ready SHALL be 0 from the next cycle on.
REQ-013 SETTLE: the settle counter SHALL decrement each cycle; on the cycle it reaches 0 the block SHALL return to IDLE, pulse done for one cycle and set filter_ready=1.
REQ-014 The cycle from the last coef_write_enable to done SHALL be NUM_TAPS+1 cycles, covering the filter's NUM_TAPS-stage output latency.
REQ-015 start in LOAD or SETTLE SHALL be ignored.
REQ-016 abort in LOAD or SETTLE SHALL return to IDLE in the next cycle with no further writes, no done pulse and filter_ready=0.
REQ-017 Coefficients already written before an abort are not rolled back.
REQ-018 abort in IDLE SHALL be ignored; abort and start together in IDLE SHALL give abort priority (stay in IDLE).
REQ-019 An abort asserted in the same cycle as a handshake SHALL still produce that cycle's registered write, then stop.
REQ-020 The tap counter SHALL never exceed NUM_TAPS-1; no write with coef_number >= NUM_TAPS SHALL occur.
REQ-021 busy SHALL be 1 exactly when the state is LOAD or SETTLE.

Reset
REQ-022 rst=1 SHALL asynchronously force IDLE, both counters to 0, and all outputs to 0 (s_ready, coef_write_enable, coef_number, coef_value, busy, done, filter_ready).
REQ-023 Reset asserted mid-LOAD SHALL drop coef_write_enable within the same cycle; no resumption occurs after reset release.
REQ-024 After reset release the block SHALL wait in IDLE for start.

Verification
REQ-025 Back-to-back load: start, then s_valid=1 continuously with s_data=1..10 -> 10 consecutive write strobes with (number,value) = (0,1)..(9,10); done 11 cycles after the last strobe; filter_ready=1.
REQ-026 Gapped stream: s_valid toggled 1/0, data 0xA0..0xA9 -> strobes only on accepted beats, values in order; done timing relative to the last strobe unchanged.
REQ-027 Abort after 4 beats -> exactly 4 strobes (taps 0..3); IDLE next cycle; done never pulses; filter_ready=0.
REQ-028 Async reset mid-SETTLE -> all outputs 0 immediately; no done pulse; a fresh start reloads from tap 0.
REQ-029 start pulsed during LOAD and SETTLE -> no restart; the tap sequence stays monotonic; exactly one done pulse.
REQ-030 End-to-end with the filter: load taps 1,0,0,...,0; after done, drive impulse 5 -> filter output 5 one cycle after the impulse and 0 otherwise.
